// File: rtl/nibble_serial_adder_if.sv
// Valid/ready operand and result bundle for nibble_serial_adder.
// Optional sub lane present when NIBBLE_SERIAL_SUB_EN is defined.
interface nibble_serial_adder_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
`ifdef NIBBLE_SERIAL_SUB_EN
   logic             sub;
`endif
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             overflow;

   modport master (
`ifdef NIBBLE_SERIAL_SUB_EN
      output sub,
`endif
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout, overflow
   );

   modport slave (
`ifdef NIBBLE_SERIAL_SUB_EN
      input  sub,
`endif
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout, overflow
   );
endinterface

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one 4-bit carry-lookahead slice, one nibble per clock, LSB first.
// Define NIBBLE_SERIAL_SUB_EN to add a sub lane that turns the operation into a - b.
//
// state | meaning
// IDLE  | in_ready high, waiting for operands
// RUN   | one nibble added per cycle, carry held between nibbles
// DONE  | out_valid high, result held until out_ready
module nibble_serial_adder #(
   parameter int WIDTH = 16
) (
   input logic                  clk,
   input logic                  rst_n,
   nibble_serial_adder_if.slave bus
);
   localparam int NIB = WIDTH / 4;
   localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

   generate
      if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_width_check
         $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t              state;
   logic [NIB-1:0][3:0] a_q;
   logic [NIB-1:0][3:0] b_q;
   logic [NIB-1:0][3:0] sum_q;
   logic                carry_q;
   logic [IW-1:0]       idx;
   logic                in_ready_q;
   logic                out_valid_q;
   logic                cout_q;
   logic                ovf_q;

   logic [WIDTH-1:0]    b_eff;
   logic                c_init;

`ifdef NIBBLE_SERIAL_SUB_EN
   assign b_eff  = bus.sub ? ~bus.b : bus.b;
   assign c_init = bus.sub ? 1'b1 : bus.cin;
`else
   assign b_eff  = bus.b;
   assign c_init = bus.cin;
`endif

   // 4-bit carry-lookahead slice on the current nibble
   logic [3:0] sl_a;
   logic [3:0] sl_b;
   logic [3:0] sl_g;
   logic [3:0] sl_p;
   logic [3:0] sl_s;
   logic [4:0] sl_c;

   always_comb begin
      sl_a    = a_q[idx];
      sl_b    = b_q[idx];
      sl_g    = sl_a & sl_b;
      sl_p    = sl_a ^ sl_b;
      sl_c[0] = carry_q;
      sl_c[1] = sl_g[0] | (sl_p[0] & sl_c[0]);
      sl_c[2] = sl_g[1] | (sl_p[1] & sl_g[0]) | (sl_p[1] & sl_p[0] & sl_c[0]);
      sl_c[3] = sl_g[2] | (sl_p[2] & sl_g[1]) | (sl_p[2] & sl_p[1] & sl_g[0])
              | (sl_p[2] & sl_p[1] & sl_p[0] & sl_c[0]);
      sl_c[4] = sl_g[3] | (sl_p[3] & sl_g[2]) | (sl_p[3] & sl_p[2] & sl_g[1])
              | (sl_p[3] & sl_p[2] & sl_p[1] & sl_g[0])
              | (sl_p[3] & sl_p[2] & sl_p[1] & sl_p[0] & sl_c[0]);
      sl_s    = sl_p ^ sl_c[3:0];
   end

   logic last_nib;
   assign last_nib = (idx == IW'(NIB - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         sum_q       <= '0;
         carry_q     <= 1'b0;
         idx         <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  a_q        <= bus.a;
                  b_q        <= b_eff;
                  carry_q    <= c_init;
                  idx        <= '0;
                  in_ready_q <= 1'b0;
                  state      <= RUN;
               end
            end
            RUN: begin
               sum_q[idx] <= sl_s;
               carry_q    <= sl_c[4];
               if (last_nib) begin
                  cout_q      <= sl_c[4];
                  // signed overflow: like-signed operands, result sign differs
                  ovf_q       <= (a_q[NIB-1][3] == b_q[NIB-1][3]) && (sl_s[3] != a_q[NIB-1][3]);
                  out_valid_q <= 1'b1;
                  state       <= DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: begin
               state       <= IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
   assign bus.overflow  = ovf_q;

endmodule
